m_cache_ctrl: RTL and testbench

//  Sequencer for the 4-word write-noallocate data cache (m_cache).
//  - Accepts single 32-bit load/store requests from the core.
//  - Drives the cache lookup port.
//  - On a read miss, fetches the 128-bit line from memory, installs it and

---
 rtl/m_cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_m_cache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cache_ctrl.sv
// m_cache_ctrl: request sequencer for the 4-word write-noallocate data cache.
// Loads look up the cache one cycle after acceptance. Load misses fetch the
// whole line from memory and install it. Stores go through to memory and
// update the cache only when the cache itself reports a hit.
module m_cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_c_addr,
  output logic                  o_c_we,
  output logic [31:0]           o_c_wdata,
  input  logic [127:0]          i_c_rdata,
  input  logic                  i_c_rhit,
  output logic                  o_c_ie,
  output logic [ADDR_WIDTH-1:0] o_c_iaddr,
  output logic [127:0]          o_c_idata,
  output logic                  o_m_req,
  output logic                  o_m_we,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [31:0]           o_m_wdata,
  input  logic                  i_m_ack,
  input  logic [127:0]          i_m_rdata,
  output logic [CNT_WIDTH-1:0]  o_hits,
  output logic [CNT_WIDTH-1:0]  o_misses
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    FETCH   = 3'd2,
    INSTALL = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [127:0]            line_q, line_d;
  logic [CNT_WIDTH-1:0]    hits_q, hits_d;
  logic [CNT_WIDTH-1:0]    misses_q, misses_d;

  logic [ADDR_WIDTH-1:0]   line_addr;
  logic                    accept;

  assign line_addr = {addr_q[ADDR_WIDTH-1:4], 4'b0000};
  assign accept    = (state_q == IDLE) && i_req && !i_rst;

  // State and request registers; async reset drops any in-flight request
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      line_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  // Next-state, register updates and all port outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    line_d    = line_q;
    hits_d    = hits_q;
    misses_d  = misses_q;

    o_ready   = (state_q == IDLE);
    o_done    = 1'b0;
    o_rdata   = '0;
    o_c_addr  = addr_q;
    o_c_we    = 1'b0;
    o_c_wdata = wdata_q;
    o_c_ie    = 1'b0;
    o_c_iaddr = line_addr;
    o_c_idata = line_q;
    o_m_req   = 1'b0;
    o_m_we    = we_q;
    o_m_addr  = we_q ? addr_q : line_addr;
    o_m_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        // Present the core address directly so the cache read starts now
        o_c_addr  = i_addr;
        o_c_wdata = i_wdata;
        if (accept) begin
          addr_d  = i_addr;
          we_d    = i_we;
          wdata_d = i_wdata;
          if (i_we) begin
            o_c_we  = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (i_c_rhit) begin
          o_done  = 1'b1;
          o_rdata = i_c_rdata[{addr_q[3:2], 5'b00000} +: 32];
          hits_d  = hits_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end else begin
          misses_d = misses_q + CNT_WIDTH'(1);
          state_d  = FETCH;
        end
      end
      FETCH: begin
        o_m_req  = 1'b1;
        o_m_we   = 1'b0;
        o_m_addr = line_addr;
        if (i_m_ack) begin
          line_d  = i_m_rdata;
          state_d = INSTALL;
        end
      end
      INSTALL: begin
        o_c_ie  = 1'b1;
        o_done  = 1'b1;
        o_rdata = line_q[{addr_q[3:2], 5'b00000} +: 32];
        state_d = IDLE;
      end
      WRITE: begin
        o_m_req  = 1'b1;
        o_m_we   = 1'b1;
        o_m_addr = addr_q;
        if (i_m_ack) begin
          o_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_hits   = hits_q;
  assign o_misses = misses_q;

endmodule

// File: tb/tb_m_cache_ctrl.sv
// tb_m_cache_ctrl: directed bench for m_cache_ctrl with a small one-line
// cache model, a latency-programmable memory model and a scoreboard that a
// separate monitor drains on every o_done pulse.
module tb_m_cache_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_req = 1'b0;
  logic           i_we = 1'b0;
  logic [AW-1:0]  i_addr = '0;
  logic [31:0]    i_wdata = '0;
  logic           o_ready, o_done;
  logic [31:0]    o_rdata;
  logic [AW-1:0]  o_c_addr;
  logic           o_c_we;
  logic [31:0]    o_c_wdata;
  logic [127:0]   c_rdata;
  logic           c_rhit;
  logic           o_c_ie;
  logic [AW-1:0]  o_c_iaddr;
  logic [127:0]   o_c_idata;
  logic           o_m_req, o_m_we;
  logic [AW-1:0]  o_m_addr;
  logic [31:0]    o_m_wdata;
  logic           m_ack;
  logic [127:0]   m_rdata;
  logic [CW-1:0]  o_hits, o_misses;

  always #5 clk = ~clk;

  m_cache_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata),
    .o_c_addr(o_c_addr), .o_c_we(o_c_we), .o_c_wdata(o_c_wdata),
    .i_c_rdata(c_rdata), .i_c_rhit(c_rhit), .o_c_ie(o_c_ie),
    .o_c_iaddr(o_c_iaddr), .o_c_idata(o_c_idata), .o_m_req(o_m_req),
    .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .i_m_ack(m_ack), .i_m_rdata(m_rdata), .o_hits(o_hits), .o_misses(o_misses)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // One-line cache model: registered lookup address, hit-only store update
  logic          c_valid = 1'b0;
  logic [AW-5:0] c_tag = '0;
  logic [127:0]  c_line = '0;
  logic [AW-1:0] c_rd_addr = '0;
  always @(posedge clk) begin
    c_rd_addr <= o_c_addr;
    if (o_c_we && c_valid && c_tag == o_c_addr[AW-1:4])
      c_line[{o_c_addr[3:2], 5'b00000} +: 32] <= o_c_wdata;
    if (o_c_ie) begin
      c_valid <= 1'b1;
      c_tag   <= o_c_iaddr[AW-1:4];
      c_line  <= o_c_idata;
    end
  end
  assign c_rhit  = c_valid && (c_tag == c_rd_addr[AW-1:4]);
  assign c_rdata = c_line;

  // Memory model: acks after mem_delay request cycles, word-addressed store
  logic [31:0] mem [logic [31:0]];
  int unsigned mem_delay = 1;
  int unsigned wait_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack    <= 1'b0;
      m_rdata  <= '0;
      wait_cnt <= 0;
    end else if (o_m_req && !m_ack) begin
      if (wait_cnt + 1 >= mem_delay) begin
        m_ack    <= 1'b1;
        wait_cnt <= 0;
        if (o_m_we) begin
          mem[o_m_addr] = o_m_wdata;
        end else begin
          for (int i = 0; i < 4; i++) begin
            logic [31:0] k;
            k = o_m_addr + 32'(4 * i);
            m_rdata[i*32 +: 32] <= mem.exists(k) ? mem[k] : 32'h0;
          end
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      m_ack <= 1'b0;
    end
  end

  // Scoreboard
  typedef struct {
    bit          is_load;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb[$];

  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  int          ie_cnt = 0;
  int          both_cnt = 0;
  int          mreq_cnt = 0;
  logic [AW-1:0] last_iaddr = '0;
  logic [AW-1:0] last_m_addr = '0;
  logic          last_m_we = 1'b0;
  logic [31:0]   last_m_wdata = '0;

  // Monitor: samples on the falling edge, drains the scoreboard on o_done
  always @(negedge clk) begin
    if (o_c_we && o_c_ie) both_cnt++;
    if (o_c_ie) begin
      ie_cnt++;
      last_iaddr = o_c_iaddr;
    end
    if (o_m_req) begin
      mreq_cnt++;
      last_m_addr  = o_m_addr;
      last_m_we    = o_m_we;
      last_m_wdata = o_m_wdata;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: o_done=1 with empty scoreboard, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_load) check({e.name, "_rdata"}, o_rdata, e.data);
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
    int unsigned n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) timeout({nm, "_ready"});
    sb.push_back('{is_load: !we, data: exp, name: nm});
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wd;
    acc_cyc = cyc;
    @(posedge clk); #1;
    i_req = 1'b0; i_we = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int start;
    bit got;
    start = done_cnt;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk); #2;
      if (done_cnt != start) got = 1'b1;
    end
    if (!got) timeout({nm, "_done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ie_before;
    mem[32'h100] = 32'h1111_0000;
    mem[32'h104] = 32'h2222_1111;
    mem[32'h108] = 32'h3333_2222;
    mem[32'h10C] = 32'h4444_3333;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done, 0);
    check("rst_mreq", o_m_req, 0);
    check("rst_hits", o_hits, 0);
    check("rst_misses", o_misses, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: cold load miss, ack after 3 request cycles
    mem_delay = 3;
    issue(1'b0, 32'h100, 0, 32'h1111_0000, "t1_load_miss");
    wait_done("t1");
    check("t1_m_addr", last_m_addr, 32'h100);
    check("t1_m_we", last_m_we, 0);
    check("t1_iaddr", last_iaddr, 32'h100);
    check("t1_misses", o_misses, 1);
    check("t1_latency", 32'(done_cyc - acc_cyc), 6);

    // 2: hit to the freshly installed line, issued right after done
    mreq_cnt = 0;
    issue(1'b0, 32'h108, 0, 32'h3333_2222, "t2_load_hit");
    wait_done("t2");
    check("t2_latency", 32'(done_cyc - acc_cyc), 1);
    check("t2_no_mreq", mreq_cnt, 0);
    check("t2_hits", o_hits, 1);

    // 3: store hit then reload
    mem_delay = 2;
    issue(1'b1, 32'h104, 32'hCAFE, 0, "t3_store");
    wait_done("t3s");
    check("t3_m_addr", last_m_addr, 32'h104);
    check("t3_m_we", last_m_we, 1);
    check("t3_m_wdata", last_m_wdata, 32'hCAFE);
    issue(1'b0, 32'h104, 0, 32'hCAFE, "t3_load");
    wait_done("t3l");
    check("t3_hits", o_hits, 2);

    // 4: store miss (no allocate), then the load misses and fetches
    issue(1'b1, 32'h2000, 32'h5, 0, "t4_store");
    wait_done("t4s");
    check("t4_m_addr", last_m_addr, 32'h2000);
    check("t4_m_we", last_m_we, 1);
    check("t4_misses_store", o_misses, 1);
    issue(1'b0, 32'h2000, 0, 32'h5, "t4_load");
    wait_done("t4l");
    check("t4_fetch_addr", last_m_addr, 32'h2000);
    check("t4_fetch_we", last_m_we, 0);
    check("t4_misses", o_misses, 2);
    check("t4_iaddr", last_iaddr, 32'h2000);

    // 5: reset during FETCH
    mem_delay = 10;
    ie_before = ie_cnt;
    issue(1'b0, 32'h3000, 0, 0, "t5_load");
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (o_m_req) seen = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!seen) timeout("t5_fetch");
    end
    rst = 1'b1;
    sb.delete();
    #1;
    check("t5_mreq", o_m_req, 0);
    check("t5_ready", o_ready, 1);
    check("t5_hits", o_hits, 0);
    check("t5_misses", o_misses, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_no_ie", ie_cnt - ie_before, 0);

    // 6: hit counter wrap with a 4-bit counter
    mem_delay = 1;
    for (int i = 0; i < 15; i++) begin
      issue(1'b0, 32'h2000, 0, 32'h5, "t6_hit");
      wait_done("t6");
    end
    check("t6_hits_max", o_hits, 15);
    issue(1'b0, 32'h2000, 0, 32'h5, "t6_wrap");
    wait_done("t6w");
    check("t6_hits_wrap", o_hits, 0);
    check("t6_misses", o_misses, 0);

    repeat (3) @(posedge clk);
    #1;
    check("we_ie_exclusive", both_cnt, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
